// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int REG_W_DEF = 5;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_REG   = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    // The younger producer (EX/MEM) holds the most recent value of the register.
    function automatic logic [1:0] fwd_select(input logic exmem_hit, input logic memwb_hit);
        logic [1:0] sel;
        if (exmem_hit) begin
            sel = FWD_EXMEM;
        end else if (memwb_hit) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller: register indices,
// write flags and memory handshake in; stage enables, flushes and forwarding out.
interface hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = 32
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_wr;
    logic             ex_is_load;
    logic [REG_W-1:0] mem_rd;
    logic             mem_wr;
    logic [REG_W-1:0] wb_rd;
    logic             wb_wr;
    logic             br_taken;
    logic             dmem_req;
    logic             dmem_ack;

    logic             en_pc;
    logic             en_ifid;
    logic             en_idex;
    logic             en_exmem;
    logic             en_memwb;
    logic             flush_ifid;
    logic             flush_idex;
    logic             pc_sel;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rd, ex_wr, ex_is_load, mem_rd, mem_wr, wb_rd, wb_wr,
        output br_taken, dmem_req, dmem_ack,
        input  en_pc, en_ifid, en_idex, en_exmem, en_memwb,
        input  flush_ifid, flush_idex, pc_sel, fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rd, ex_wr, ex_is_load, mem_rd, mem_wr, wb_rd, wb_wr,
        input  br_taken, dmem_req, dmem_ack,
        output en_pc, en_ifid, en_idex, en_exmem, en_memwb,
        output flush_ifid, flush_idex, pc_sel, fwd_a, fwd_b, stall_cnt
    );

endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// Per-operand rd/rs comparator: flags producers of the source register and
// picks its forwarding source (HAZARD_FWD_EN enables forwarding).
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] rs,
    input  logic             use_rs,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_wr,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_wr,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_wr,
    output logic             ex_match,
    output logic             older_match,
    output logic [1:0]       fwd
);

    logic mem_hit_s;
    logic wb_hit_s;

    // x0 is hardwired to zero, so it never creates a dependency.
    always_comb begin
        ex_match  = use_rs && ex_wr  && (ex_rd  == rs) && (ex_rd  != {REG_W{1'b0}});
        mem_hit_s = use_rs && mem_wr && (mem_rd == rs) && (mem_rd != {REG_W{1'b0}});
        wb_hit_s  = use_rs && wb_wr  && (wb_rd  == rs) && (wb_rd  != {REG_W{1'b0}});
        older_match = mem_hit_s | wb_hit_s;
    end

`ifdef HAZARD_FWD_EN
    assign fwd = fwd_select(mem_hit_s, wb_hit_s);
`else
    assign fwd = FWD_REG;
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stage enables, bubble/flush selects, branch
// redirect and data-memory freeze. Define HAZARD_FWD_EN for operand forwarding.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;

    logic       ex_hit_a_s;
    logic       ex_hit_b_s;
    logic       old_hit_a_s;
    logic       old_hit_b_s;
    logic [1:0] fwd_a_raw_s;
    logic [1:0] fwd_b_raw_s;
    logic       freeze_s;
    logic       hazard_s;

    logic       en_pc_s;
    logic       en_ifid_s;
    logic       en_idex_s;
    logic       en_exmem_s;
    logic       en_memwb_s;
    logic       flush_ifid_s;
    logic       flush_idex_s;
    logic       pc_sel_s;
    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;

    fwd_unit #(.REG_W(REG_W)) u_fwd_a (
        .rs          (bus.id_rs1),
        .use_rs      (bus.id_use_rs1),
        .ex_rd       (bus.ex_rd),
        .ex_wr       (bus.ex_wr),
        .mem_rd      (bus.mem_rd),
        .mem_wr      (bus.mem_wr),
        .wb_rd       (bus.wb_rd),
        .wb_wr       (bus.wb_wr),
        .ex_match    (ex_hit_a_s),
        .older_match (old_hit_a_s),
        .fwd         (fwd_a_raw_s)
    );

    fwd_unit #(.REG_W(REG_W)) u_fwd_b (
        .rs          (bus.id_rs2),
        .use_rs      (bus.id_use_rs2),
        .ex_rd       (bus.ex_rd),
        .ex_wr       (bus.ex_wr),
        .mem_rd      (bus.mem_rd),
        .mem_wr      (bus.mem_wr),
        .wb_rd       (bus.wb_rd),
        .wb_wr       (bus.wb_wr),
        .ex_match    (ex_hit_b_s),
        .older_match (old_hit_b_s),
        .fwd         (fwd_b_raw_s)
    );

`ifdef HAZARD_FWD_EN
    assign hazard_s = bus.ex_is_load & (ex_hit_a_s | ex_hit_b_s);
`else
    assign hazard_s = ex_hit_a_s | ex_hit_b_s | old_hit_a_s | old_hit_b_s;
`endif

    // The acknowledge cycle itself is a normal cycle, so freeze needs !dmem_ack.
    assign freeze_s = !bus.dmem_ack &&
                      ((state_r == MEM_WAIT) || ((state_r == RUN) && bus.dmem_req));

    // State register; reset aborts any state, including a pending memory wait.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= HOLD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            HOLD: begin
                state_nxt_s = RUN;
            end
            RUN: begin
                if (bus.dmem_req && !bus.dmem_ack) begin
                    state_nxt_s = MEM_WAIT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_ack) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = MEM_WAIT;
                end
            end
            default: begin
                state_nxt_s = HOLD;
            end
        endcase
    end

    // Stage control: freeze > branch > hazard bubble > normal flow.
    always_comb begin
        en_pc_s      = 1'b0;
        en_ifid_s    = 1'b0;
        en_idex_s    = 1'b0;
        en_exmem_s   = 1'b0;
        en_memwb_s   = 1'b0;
        flush_ifid_s = 1'b1;
        flush_idex_s = 1'b1;
        pc_sel_s     = 1'b0;
        fwd_a_s      = FWD_REG;
        fwd_b_s      = FWD_REG;
        case (state_r)
            RUN, MEM_WAIT: begin
                fwd_a_s = fwd_a_raw_s;
                fwd_b_s = fwd_b_raw_s;
                if (freeze_s) begin
                    flush_ifid_s = 1'b0;
                    flush_idex_s = 1'b0;
                end else if (bus.br_taken) begin
                    en_pc_s    = 1'b1;
                    en_ifid_s  = 1'b1;
                    en_idex_s  = 1'b1;
                    en_exmem_s = 1'b1;
                    en_memwb_s = 1'b1;
                    pc_sel_s   = 1'b1;
                end else if (hazard_s) begin
                    en_idex_s    = 1'b1;
                    en_exmem_s   = 1'b1;
                    en_memwb_s   = 1'b1;
                    flush_ifid_s = 1'b0;
                end else begin
                    en_pc_s      = 1'b1;
                    en_ifid_s    = 1'b1;
                    en_idex_s    = 1'b1;
                    en_exmem_s   = 1'b1;
                    en_memwb_s   = 1'b1;
                    flush_ifid_s = 1'b0;
                    flush_idex_s = 1'b0;
                end
            end
            default: begin
                flush_ifid_s = 1'b1;
                flush_idex_s = 1'b1;
            end
        endcase
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!en_pc_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bus.en_pc      = en_pc_s;
    assign bus.en_ifid    = en_ifid_s;
    assign bus.en_idex    = en_idex_s;
    assign bus.en_exmem   = en_exmem_s;
    assign bus.en_memwb   = en_memwb_s;
    assign bus.flush_ifid = flush_ifid_s;
    assign bus.flush_idex = flush_idex_s;
    assign bus.pc_sel     = pc_sel_s;
    assign bus.fwd_a      = fwd_a_s;
    assign bus.fwd_b      = fwd_b_s;
    assign bus.stall_cnt  = cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vector bench for hazard_ctrl (expectations follow HAZARD_FWD_EN).
module tb_hazard_ctrl;
    import hazard_pkg::*;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // ctl = {en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, pc_sel}
    localparam logic [7:0] C_NORM = 8'b11111_00_0;
    localparam logic [7:0] C_BUB  = 8'b00111_01_0;
    localparam logic [7:0] C_BR   = 8'b11111_11_1;
    localparam logic [7:0] C_FRZ  = 8'b00000_00_0;
    localparam logic [7:0] C_HLD  = 8'b00000_11_0;

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] ex_rd;
        logic       ex_wr, ex_ld;
        logic [4:0] mem_rd;
        logic       mem_wr;
        logic [4:0] wb_rd;
        logic       wb_wr;
        logic       br, req, ack;
        logic [7:0] ctl;
        logic [1:0] fa, fb;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   exp_cnt;
    int   cnt0;
    vec_t vecs[$];

    hazard_ctrl_if #(.REG_W(5), .CNT_W(32)) hif ();

    hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string nm,
                                logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                                logic [4:0] exrd, logic exwr, logic exld,
                                logic [4:0] mrd, logic mwr, logic [4:0] wrd, logic wwr,
                                logic br, logic req, logic ack,
                                logic [7:0] ctl, logic [1:0] fa, logic [1:0] fb);
        vec_t v;
        v.name = nm; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.ex_rd = exrd; v.ex_wr = exwr; v.ex_ld = exld;
        v.mem_rd = mrd; v.mem_wr = mwr; v.wb_rd = wrd; v.wb_wr = wwr;
        v.br = br; v.req = req; v.ack = ack;
        v.ctl = ctl; v.fa = fa; v.fb = fb;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        hif.id_rs1 = v.rs1;     hif.id_use_rs1 = v.u1;
        hif.id_rs2 = v.rs2;     hif.id_use_rs2 = v.u2;
        hif.ex_rd  = v.ex_rd;   hif.ex_wr = v.ex_wr; hif.ex_is_load = v.ex_ld;
        hif.mem_rd = v.mem_rd;  hif.mem_wr = v.mem_wr;
        hif.wb_rd  = v.wb_rd;   hif.wb_wr = v.wb_wr;
        hif.br_taken = v.br;    hif.dmem_req = v.req; hif.dmem_ack = v.ack;
    endtask

    task automatic check_now(string nm, logic [7:0] ctl, logic [1:0] fa, logic [1:0] fb);
        logic [7:0] act;
        act = {hif.en_pc, hif.en_ifid, hif.en_idex, hif.en_exmem, hif.en_memwb,
               hif.flush_ifid, hif.flush_idex, hif.pc_sel};
        chk({nm, ".ctl"}, {24'd0, act}, {24'd0, ctl});
        chk({nm, ".fwd_a"}, {30'd0, hif.fwd_a}, {30'd0, fa});
        chk({nm, ".fwd_b"}, {30'd0, hif.fwd_b}, {30'd0, fb});
        chk({nm, ".stall_cnt"}, hif.stall_cnt, exp_cnt);
    endtask

    // Apply one vector, check mid-cycle, then advance past the next rising edge.
    task automatic apply(vec_t v);
        drive(v);
        #2;
        check_now(v.name, v.ctl, v.fa, v.fb);
        @(posedge clk);
        #1;
        if (v.ctl[7] == 1'b0) exp_cnt++;
    endtask

    initial begin
        vec_t idle;
        total = 0; bad = 0; exp_cnt = 0;
        idle = mk("idle", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                  1'b0, 1'b0, 1'b0, C_NORM, 2'd0, 2'd0);

        vecs.push_back(mk("hold", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                          1'b0, 1'b0, 1'b0, C_HLD, 2'd0, 2'd0));
        vecs.push_back(mk("run_idle", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                          1'b0, 1'b0, 1'b0, C_NORM, 2'd0, 2'd0));
        vecs.push_back(mk("load_use", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0,
                          1'b0, 1'b0, 1'b0, C_BUB, 2'd0, 2'd0));
        vecs.push_back(mk("load_in_exmem", 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0,
                          1'b0, 1'b0, 1'b0, FWD ? C_NORM : C_BUB, FWD ? 2'd1 : 2'd0, 2'd0));
        vecs.push_back(mk("x0_never", 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1,
                          1'b0, 1'b0, 1'b0, C_NORM, 2'd0, 2'd0));
        vecs.push_back(mk("use_off", 5'd0, 1'b0, 5'd3, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0,
                          1'b0, 1'b0, 1'b0, C_NORM, 2'd0, 2'd0));
        vecs.push_back(mk("wb_rs2", 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1,
                          1'b0, 1'b0, 1'b0, FWD ? C_NORM : C_BUB, 2'd0, FWD ? 2'd2 : 2'd0));
        vecs.push_back(mk("exmem_prio", 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 5'd4, 1'b1,
                          1'b0, 1'b0, 1'b0, FWD ? C_NORM : C_BUB, FWD ? 2'd1 : 2'd0, 2'd0));
        vecs.push_back(mk("mem_wr_off", 5'd0, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 5'd6, 1'b0, 5'd0, 1'b0,
                          1'b0, 1'b0, 1'b0, C_NORM, 2'd0, 2'd0));
        vecs.push_back(mk("x7_ex", 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                          1'b0, 1'b0, 1'b0, FWD ? C_NORM : C_BUB, 2'd0, 2'd0));
        vecs.push_back(mk("x7_mem", 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0,
                          1'b0, 1'b0, 1'b0, FWD ? C_NORM : C_BUB, FWD ? 2'd1 : 2'd0, 2'd0));
        vecs.push_back(mk("x7_wb", 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1,
                          1'b0, 1'b0, 1'b0, FWD ? C_NORM : C_BUB, FWD ? 2'd2 : 2'd0, 2'd0));
        vecs.push_back(mk("x7_done", 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                          1'b0, 1'b0, 1'b0, C_NORM, 2'd0, 2'd0));
        vecs.push_back(mk("br_over_hazard", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0,
                          1'b1, 1'b0, 1'b0, C_BR, 2'd0, 2'd0));
        vecs.push_back(mk("freeze_over_br", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0,
                          1'b1, 1'b1, 1'b0, C_FRZ, 2'd0, 2'd0));
        vecs.push_back(mk("wait_br", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                          1'b1, 1'b1, 1'b0, C_FRZ, 2'd0, 2'd0));
        vecs.push_back(mk("wait_noreq", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                          1'b0, 1'b0, 1'b0, C_FRZ, 2'd0, 2'd0));
        vecs.push_back(mk("ack_br", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                          1'b1, 1'b1, 1'b1, C_BR, 2'd0, 2'd0));
        vecs.push_back(mk("req_ack_run", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                          1'b0, 1'b1, 1'b1, C_NORM, 2'd0, 2'd0));
        vecs.push_back(mk("back_in_run", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                          1'b0, 1'b0, 1'b0, C_NORM, 2'd0, 2'd0));

        rst = 1'b0;
        drive(idle);
        repeat (2) @(posedge clk);
        #1;
        check_now("in_reset", C_HLD, 2'd0, 2'd0);
        rst = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Three cycles without ack, then the ack cycle runs normally.
        cnt0 = exp_cnt;
        for (int k = 0; k < 3; k++) begin
            vec_t w;
            w = idle; w.name = $sformatf("memwait%0d", k); w.req = 1'b1; w.ctl = C_FRZ;
            apply(w);
        end
        chk("memwait.cnt_plus3", hif.stall_cnt, cnt0 + 3);
        begin
            vec_t a;
            a = idle; a.name = "memwait_ack"; a.req = 1'b1; a.ack = 1'b1;
            apply(a);
        end
        apply(idle);

        // Reset asserted while in MEM_WAIT clears everything at once.
        begin
            vec_t w;
            w = idle; w.name = "pre_reset_wait"; w.req = 1'b1; w.ctl = C_FRZ;
            apply(w);
        end
        hif.id_rs1 = 5'd4; hif.id_use_rs1 = 1'b1; hif.mem_rd = 5'd4; hif.mem_wr = 1'b1;
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        check_now("reset_mid_wait", C_HLD, 2'd0, 2'd0);
        @(posedge clk);
        #1;
        drive(idle);
        rst = 1'b1;
        begin
            vec_t h;
            h = idle; h.name = "hold_after_rst"; h.ctl = C_HLD;
            apply(h);
        end
        begin
            vec_t r;
            r = idle; r.name = "run_after_rst";
            apply(r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage CPU. It drives the per-stage enables of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers and the PC. It also drives the bubble-insertion (flush) selects that force a stage's op_data input to NOP. It detects load-use and RAW hazards, redirects on taken branches, and freezes the pipeline while data memory is busy, tracking that condition in a small FSM.

## Interface
Parameters:
- REG_W, 5, register index width.
- CNT_W, 32, stall-cycle counter width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  REG_W  source registers of instruction in IF/ID.
- id_use_rs1, id_use_rs2  in  1  instruction in IF/ID reads that source.
- ex_rd  in  REG_W  destination in ID/EX.
- ex_wr, ex_is_load  in  1  ID/EX writes rd / is a load.
- mem_rd, wb_rd  in  REG_W  destinations in EX/MEM and MEM/WB.
- mem_wr, wb_wr  in  1  write flags for those stages.
- br_taken  in  1  branch/jump resolved taken in EX.
- dmem_req, dmem_ack  in  1  MEM-stage access request and completion.
- en_pc, en_ifid, en_idex, en_exmem, en_memwb  out  1  stage enables.
- flush_ifid, flush_idex  out  1  select NOP into that stage's op_data.
- pc_sel  out  1  1 = PC loads branch target.
- fwd_a, fwd_b  out  2  ALU operand source: 0 reg file, 1 EX/MEM, 2 MEM/WB.
- stall_cnt  out  CNT_W  total cycles with en_pc=0 since reset.

## Operation
- FSM states:
  - HOLD: entered on reset; lasts 1 cycle after rst rises.
  - RUN.
  - MEM_WAIT.
- HOLD: all enables 0, both flushes 1. Next state is RUN.
- RUN → MEM_WAIT when dmem_req=1 and dmem_ack=0.
- MEM_WAIT → RUN on the cycle dmem_ack=1.
- Freeze: in MEM_WAIT, or in RUN with dmem_req&!dmem_ack. All enables 0, flushes 0, pc_sel 0. Freeze takes priority over all other conditions.
- Branch: br_taken=1 and no freeze.
  - All enables 1, pc_sel=1, flush_ifid=1, flush_idex=1.
  - Branch overrides any hazard, since the stalled instruction is squashed anyway.
- Hazard: no freeze and no branch.
  - en_pc=0, en_ifid=0, en_idex=1 with flush_idex=1 (bubble); en_exmem=en_memwb=1.
- Otherwise all enables 1, flushes 0, pc_sel 0.
- Register match: rd equal to rs, rd≠0, the stage's write flag set, and the matching use flag set.
- Forwarding selects:
  - EX/MEM match takes priority over MEM/WB match.
  - The value is 0 when there is no match or when the macro is undefined.
- stall_cnt increments by 1 each cycle en_pc=0, including HOLD. It saturates at all-ones.
- Reset (any time, including mid-MEM_WAIT) aborts the current state immediately.

## Timing
- Enables, flushes, pc_sel and fwd_* are combinational from the current inputs and the state register. They are valid before the rising edge they qualify.
- State and stall_cnt are registered.
- Reset values: state=HOLD, stall_cnt=0. During reset and HOLD the outputs are all enables 0, flushes 1, pc_sel 0, fwd 0.
- Load-use hazard: exactly 1 bubble cycle per occurrence. On the next cycle the load sits in EX/MEM and forwarding (or a further stall) resolves.
- A MEM_WAIT of N cycles without ack produces N frozen cycles. The first cycle with dmem_ack=1 is a normal cycle.
- br_taken together with dmem_req&!dmem_ack: freeze wins. The branch is re-evaluated when the freeze ends, because ID/EX is held.

## Configuration
- HAZARD_FWD_EN defined:
  - Hazard = load-use only: ex_is_load&ex_wr and ex_rd matches a used source.
  - fwd_a/fwd_b are active.
- HAZARD_FWD_EN undefined:
  - Hazard = a used source matches any of ex_rd/mem_rd/wb_rd with its write flag set.
  - The stall repeats each cycle until there is no match.
  - fwd_a/fwd_b are tied to 0.

## Structure
- Shared package hazard_pkg holds:
  - the state enum (HOLD, RUN, MEM_WAIT);
  - FWD_REG=0, FWD_EXMEM=1, FWD_MEMWB=2;
  - the REG_W default.
- One sub-module, fwd_unit: the combinational rd/rs comparator producing match flags and fwd selects. It is instantiated once per source operand.

## Test plan
- Reset released → 1 cycle with all enables 0 and flushes 1, then RUN with all enables 1; stall_cnt=1.
- Load into x5 in ID/EX, id_rs1=5 with use flag set → en_pc=en_ifid=0, flush_idex=1 for exactly 1 cycle.
  - With HAZARD_FWD_EN: the next cycle has fwd_a=1 and no stall.
- dmem_req=1, dmem_ack low for 3 cycles → 3 frozen cycles, state MEM_WAIT, stall_cnt+3. Ack cycle restores RUN.
- br_taken=1 with a simultaneous load-use match → pc_sel=1, both flushes 1, en_pc=1.
- Without HAZARD_FWD_EN: ALU op writes x7, next instruction reads x7 → stall for 3 cycles while x7 passes EX/MEM/WB, then proceed.
- rst asserted mid-MEM_WAIT → outputs go to reset values immediately. HOLD follows release.
